dekatron_pulse_decoder: RTL and testbench

//  Receiving end of the two-wire dekatron step protocol: samples active-low PulseRight_n/PulseLeft_n
//  (forward: NONE->R->L->NONE; reverse: NONE->L->R->NONE) and tracks the glow over the 30-position ring.

---
 rtl/dekatron_pulse_decoder_pkg.sv | 39 +++
 rtl/dekatron_pulse_sync.sv | 24 ++
 rtl/dekatron_pulse_decoder.sv | 96 +++++++++
 tb/tb_dekatron_pulse_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dekatron_pulse_decoder_pkg.sv
// dekatron_pulse_decoder_pkg: pulse codes, ring phases and position/digit helpers
package dekatron_pulse_decoder_pkg;
   localparam logic [1:0] PULSE_FAIL = 2'b00;
   localparam logic [1:0] PULSE_L    = 2'b01;
   localparam logic [1:0] PULSE_R    = 2'b10;
   localparam logic [1:0] PULSE_NONE = 2'b11;
   localparam logic [1:0] PHASE_MAIN = 2'd0;
   localparam logic [1:0] PHASE_GR   = 2'd1;
   localparam logic [1:0] PHASE_GL   = 2'd2;
   localparam int         POS_COUNT  = 30;

   typedef struct packed {
      logic fwd;
      logic rev;
      logic carry;
      logic borrow;
      logic abort;
   } strobe_t;

   function automatic logic [1:0] pos_phase(input logic [4:0] p);
      return 2'(p % 5'd3);
   endfunction

   function automatic logic [3:0] pos_digit(input logic [4:0] p);
      return 4'(p / 5'd3);
   endfunction

   function automatic logic [4:0] digit_pos(input logic [3:0] d);
      return {1'b0, d} * 5'd3;
   endfunction

   function automatic logic [1:0] code_phase(input logic [1:0] c);
      return c == PULSE_R ? PHASE_GR : c == PULSE_L ? PHASE_GL : PHASE_MAIN;
   endfunction

   function automatic logic [1:0] phase_inc(input logic [1:0] ph);
      return ph == PHASE_GL ? PHASE_MAIN : ph + 2'd1;
   endfunction
endpackage

// File: rtl/dekatron_pulse_sync.sv
// dekatron_pulse_sync: optional synchroniser chain plus capture register for the 2-bit pulse code
module dekatron_pulse_sync
   import dekatron_pulse_decoder_pkg::*;
#(
   parameter int SYNC_STAGES = 0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_code,
   output logic [1:0] o_code
);
   logic [1:0] r_sh [SYNC_STAGES+1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k <= SYNC_STAGES; k++) r_sh[k] <= PULSE_NONE;
      end else begin
         r_sh[0] <= i_code;
         for (int k = 1; k <= SYNC_STAGES; k++) r_sh[k] <= r_sh[k-1];
      end
   end

   assign o_code = r_sh[SYNC_STAGES];
endmodule

// File: rtl/dekatron_pulse_decoder.sv
// dekatron_pulse_decoder: tracks the dekatron glow over its 30-position ring from
// the two-wire guide pulse protocol, producing digit, step/carry strobes and fault.
module dekatron_pulse_decoder
   import dekatron_pulse_decoder_pkg::*;
#(
   parameter int SYNC_STAGES = 0,
   parameter int INIT_DIGIT  = 0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_pulse_right_n,
   input  logic       i_pulse_left_n,
   input  logic       i_load,
   input  logic [3:0] i_load_digit,
   input  logic       i_clear_fault,
   output logic [9:0] o_out,
   output logic [3:0] o_digit,
   output logic       o_ready,
   output logic       o_step_fwd,
   output logic       o_step_rev,
   output logic       o_carry,
   output logic       o_borrow,
   output logic       o_abort,
   output logic       o_fault
);
   localparam logic [4:0] INIT_POS = digit_pos(4'(INIT_DIGIT));

   logic [1:0] w_code, w_phase, w_tgt, r_prev;
   logic [4:0] r_pos, w_pos_n, w_inc, w_dec;
   logic [3:0] r_last, w_nd;
   logic       w_change, w_legal, w_fwd, w_rev, w_main, w_ld_ok, w_det, r_fault;
   strobe_t    w_stb, r_stb;

   dekatron_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_code ({i_pulse_left_n, i_pulse_right_n}),
      .o_code (w_code)
   );

   always_comb begin
      w_change = w_code != r_prev;
      w_legal  = w_code != PULSE_FAIL;
      w_phase  = pos_phase(r_pos);
      w_tgt    = code_phase(w_code);
      w_inc    = r_pos == 5'(POS_COUNT - 1) ? 5'd0 : r_pos + 5'd1;
      w_dec    = r_pos == 5'd0 ? 5'(POS_COUNT - 1) : r_pos - 5'd1;
      w_fwd    = w_change && w_legal && w_tgt == phase_inc(w_phase);
      w_rev    = w_change && w_legal && w_tgt == phase_inc(phase_inc(w_phase));
      w_pos_n  = w_fwd ? w_inc : w_rev ? w_dec : r_pos;
      w_main   = (w_fwd || w_rev) && pos_phase(w_pos_n) == PHASE_MAIN;
      w_nd     = pos_digit(w_pos_n);
      // Borrow can only follow a -1 arrival that left main 0, i.e. 28->27
      w_stb.fwd    = w_main && w_nd != r_last && w_fwd;
      w_stb.rev    = w_main && w_nd != r_last && w_rev;
      w_stb.carry  = w_stb.fwd && r_pos == 5'(POS_COUNT - 1);
      w_stb.borrow = w_stb.rev && r_last == 4'd0;
      w_stb.abort  = w_main && w_nd == r_last;
      w_ld_ok  = i_load_digit <= 4'd9;
      w_det    = i_load ? !w_ld_ok : w_change && !w_legal;
      o_out    = w_phase == PHASE_MAIN ? 10'b1 << pos_digit(r_pos) : '0;
      o_ready  = w_phase == PHASE_MAIN && w_code == PULSE_NONE;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pos   <= INIT_POS;
         r_last  <= 4'(INIT_DIGIT);
         r_prev  <= PULSE_NONE;
         r_stb   <= '0;
         r_fault <= 1'b0;
      end else begin
         r_fault <= w_det || (r_fault && !i_clear_fault);
         r_stb   <= i_load ? '0 : w_stb;
         if (i_load) begin
            if (w_ld_ok) begin
               r_pos  <= digit_pos(i_load_digit);
               r_last <= i_load_digit;
               r_prev <= w_code;
            end
         end else begin
            r_prev <= w_code;
            r_pos  <= w_pos_n;
            if (w_main) r_last <= w_nd;
         end
      end
   end

   assign o_digit    = r_last;
   assign o_step_fwd = r_stb.fwd;
   assign o_step_rev = r_stb.rev;
   assign o_carry    = r_stb.carry;
   assign o_borrow   = r_stb.borrow;
   assign o_abort    = r_stb.abort;
   assign o_fault    = r_fault;
endmodule

// File: tb/tb_dekatron_pulse_decoder.sv
// tb_dekatron_pulse_decoder: scoreboard bench with a ring-arithmetic reference model
module tb_dekatron_pulse_decoder;
   logic       clk = 0, rst = 1;
   logic       prn = 1, pln = 1, load = 0, clr = 0;
   logic [3:0] ld = 0;
   logic [9:0] out;
   logic [3:0] digit;
   logic       ready, sf, sr, ca, bo, ab, fault;
   logic       prn2 = 1, pln2 = 1, load2 = 0;
   logic [3:0] ld2 = 0;
   logic [9:0] out2;
   logic [3:0] digit2;
   logic       ready2, sf2, sr2, ca2, bo2, ab2, fault2;

   dekatron_pulse_decoder #(.SYNC_STAGES(0), .INIT_DIGIT(0)) dut (
      .i_clk(clk), .i_rst(rst), .i_pulse_right_n(prn), .i_pulse_left_n(pln),
      .i_load(load), .i_load_digit(ld), .i_clear_fault(clr),
      .o_out(out), .o_digit(digit), .o_ready(ready), .o_step_fwd(sf), .o_step_rev(sr),
      .o_carry(ca), .o_borrow(bo), .o_abort(ab), .o_fault(fault));

   dekatron_pulse_decoder #(.SYNC_STAGES(2), .INIT_DIGIT(7)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_pulse_right_n(prn2), .i_pulse_left_n(pln2),
      .i_load(load2), .i_load_digit(ld2), .i_clear_fault(1'b0),
      .o_out(out2), .o_digit(digit2), .o_ready(ready2), .o_step_fwd(sf2), .o_step_rev(sr2),
      .o_carry(ca2), .o_borrow(bo2), .o_abort(ab2), .o_fault(fault2));

   always #5 clk = ~clk;

   typedef struct {
      int   cyc;
      logic fwd, rev, carry, borrow, abort;
      int   digit;
   } ev_t;

   ev_t  q[$];
   ev_t  me;
   int   cyc = 0, checks = 0, errors = 0;
   int   n_fwd = 0, n_rev = 0, n_carry = 0, n_borrow = 0, n_abort = 0;
   int   n2_rev = 0, n2_borrow = 0, n2_other = 0, t0 = -1, t1 = -1;
   int   m_pos = 0, m_last = 0;
   logic [1:0] m_prev = 2'b11;
   logic m_fault = 0;
   logic [4:0] s;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin
      s = {sf, sr, ca, bo, ab};
      n_fwd += int'(sf); n_rev += int'(sr); n_carry += int'(ca);
      n_borrow += int'(bo); n_abort += int'(ab);
      if (s != 0) begin
         if (q.size() == 0) chk("unexpected_strobe", 32'(s), 0);
         else begin
            me = q.pop_front();
            chk("strobes", 32'(s), 32'({me.fwd, me.rev, me.carry, me.borrow, me.abort}));
            chk("strobe_cycle", cyc, me.cyc);
            chk("strobe_digit", 32'(digit), me.digit);
         end
      end else if (q.size() != 0 && q[0].cyc < cyc) begin
         me = q.pop_front();
         chk("missed_strobe", 32'(s), 32'({me.fwd, me.rev, me.carry, me.borrow, me.abort}));
      end
      n2_rev += int'(sr2); n2_borrow += int'(bo2); n2_other += int'(sf2 | ca2 | ab2);
      if (sr2 && t1 < 0) t1 = cyc;
   end

   // Model: glow moves to the neighbour whose phase matches the code's target phase
   task automatic apply(input logic [1:0] c, input int hold);
      int tgt, np, dir, d;
      @(negedge clk);
      {pln, prn} = c;
      if (c != m_prev) begin
         m_prev = c;
         if (c == 2'b00) m_fault = 1;
         else begin
            tgt = (c == 2'b11) ? 0 : (c == 2'b10) ? 1 : 2;
            np = m_pos; dir = 0;
            if ((m_pos + 1) % 3 == tgt) begin np = (m_pos + 1) % 30; dir = 1; end
            else if ((m_pos + 29) % 3 == tgt) begin np = (m_pos + 29) % 30; dir = -1; end
            if (dir != 0 && np % 3 == 0) begin
               d = np / 3;
               if (d == m_last) q.push_back('{cyc + 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_last});
               else begin
                  q.push_back('{cyc + 2, dir > 0, dir < 0, dir > 0 && np == 0,
                                dir < 0 && np == 27 && m_last == 0, 1'b0, d});
                  m_last = d;
               end
            end
            m_pos = np;
         end
      end
      repeat (hold - 1) @(negedge clk);
   endtask

   task automatic do_load(input logic [3:0] d);
      repeat (2) @(negedge clk);
      load = 1; ld = d;
      if (d <= 9) begin m_pos = 3 * int'(d); m_last = int'(d); end
      else m_fault = 1;
      @(negedge clk);
      load = 0;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   task automatic step_fwd(input int h);
      apply(2'b10, h); apply(2'b01, h); apply(2'b11, h);
   endtask

   task automatic step_rev(input int h);
      apply(2'b01, h); apply(2'b10, h); apply(2'b11, h);
   endtask

   int b_fwd, b_rev, b_carry, b_borrow, b_abort;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_digit", 32'(digit), 0);
      chk("rst_out", 32'(out), 1);
      chk("rst_ready", 32'(ready), 1);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_strobes", 32'({sf, sr, ca, bo, ab}), 0);
      chk("rst2_digit", 32'(digit2), 7);
      chk("rst2_out", 32'(out2), 32'(1 << 7));
      rst = 0;

      b_fwd = n_fwd;
      for (int i = 0; i < 3; i++) step_fwd(1);
      settle();
      chk("t1_digit", 32'(digit), 3);
      chk("t1_out", 32'(out), 32'(10'b0000001000));
      chk("t1_stepfwd_count", n_fwd - b_fwd, 3);

      b_carry = n_carry; b_borrow = n_borrow;
      do_load(9);
      step_fwd(1);
      settle();
      chk("t2_carry_digit", 32'(digit), 0);
      step_rev(2);
      settle();
      chk("t2_borrow_digit", 32'(digit), 9);
      chk("t2_carry_count", n_carry - b_carry, 1);
      chk("t2_borrow_count", n_borrow - b_borrow, 1);

      do_load(4);
      b_fwd = n_fwd; b_abort = n_abort;
      apply(2'b10, 1); apply(2'b11, 1);
      settle();
      chk("t3_abort_count", n_abort - b_abort, 1);
      chk("t3_no_step", n_fwd - b_fwd, 0);
      chk("t3_digit", 32'(digit), 4);
      chk("t3_out", 32'(out), 32'(1 << 4));
      b_rev = n_rev;
      apply(2'b01, 5);
      settle();
      chk("t3_guide_out", 32'(out), 0);
      chk("t3_guide_ready", 32'(ready), 0);
      chk("t3_held_digit", 32'(digit), 4);
      apply(2'b10, 1); apply(2'b11, 1);
      settle();
      chk("t3_rev_digit", 32'(digit), 3);
      chk("t3_rev_count", n_rev - b_rev, 1);

      do_load(6);
      apply(2'b00, 2);
      settle();
      chk("t4_fault", 32'(fault), 32'(m_fault));
      chk("t4_fault_digit", 32'(digit), 6);
      apply(2'b11, 2);
      @(negedge clk); clr = 1; m_fault = 0;
      @(negedge clk); clr = 0;
      chk("t4_clear", 32'(fault), 32'(m_fault));
      do_load(12);
      settle();
      chk("t4_bad_load_fault", 32'(fault), 32'(m_fault));
      chk("t4_bad_load_digit", 32'(digit), 6);
      @(negedge clk); clr = 1; m_fault = 0;
      @(negedge clk); clr = 0;

      apply(2'b10, 1);
      @(negedge clk);
      rst = 1; {pln, prn} = 2'b11;
      q.delete();
      m_pos = 0; m_last = 0; m_prev = 2'b11; m_fault = 0;
      @(negedge clk);
      rst = 0;
      chk("t5_digit", 32'(digit), 0);
      chk("t5_ready", 32'(ready), 1);
      chk("t5_strobes", 32'({sf, sr, ca, bo, ab}), 0);
      chk("t5_fault", 32'(fault), 0);
      apply(2'b11, 4);
      chk("t5_no_motion", 32'(out), 1);

      for (int i = 0; i < 150; i++) begin
         int op, h;
         op = int'($urandom_range(0, 5));
         h  = int'($urandom_range(1, 3));
         case (op)
            0: step_fwd(h);
            1: step_rev(h);
            2: begin apply(2'b10, h); apply(2'b11, h); end
            3: begin apply(2'b01, h); apply(2'b11, h); end
            4: do_load(4'($urandom_range(0, 9)));
            default: begin apply(2'b10, h); apply(2'b01, h); apply(2'b10, h); apply(2'b11, h); end
         endcase
      end
      settle();
      chk("rand_digit", 32'(digit), m_last);
      chk("rand_out", 32'(out), 32'(1 << m_last));
      chk("rand_queue_drained", q.size(), 0);
      chk("rand_fault", 32'(fault), 32'(m_fault));

      @(negedge clk); load2 = 1; ld2 = 5;
      @(negedge clk); load2 = 0;
      chk("t6_load_digit", 32'(digit2), 5);
      n2_rev = 0; n2_borrow = 0; n2_other = 0; t1 = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); {pln2, prn2} = 2'b01;
         @(negedge clk); {pln2, prn2} = 2'b10;
         @(negedge clk); {pln2, prn2} = 2'b11;
         if (i == 0) t0 = cyc;
      end
      repeat (8) @(negedge clk);
      chk("t6_digit", 32'(digit2), ((5 - 20) % 10 + 10) % 10);
      chk("t6_steprev_count", n2_rev, 20);
      chk("t6_borrow_count", n2_borrow, 2);
      chk("t6_other_strobes", n2_other, 0);
      chk("t6_latency", t1 - t0, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
